// File: rtl/edge_window_pkg.sv
// Shared types and constants for the edge window measurement block.
// Holds the FSM state encoding, default widths and the count saturation helper.
package edge_window_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int CW_DEF = 8;
  localparam int WW_DEF = 8;

  // Largest value a cw-bit counter can hold; the count sticks here.
  function automatic int unsigned sat_limit(input int unsigned cw);
    return (32'd1 << cw) - 32'd1;
  endfunction

endpackage

// File: rtl/edge_window_counter_rise_detect.sv
// Level-to-pulse converter: one-cycle pulse on each rising edge of a
// CLK-synchronous level. Reusable wherever such a conversion is needed.
module rise_detect (
  input  logic CLK,
  input  logic RES,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) level_q <= 1'b0;
    else      level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/edge_window_counter.sv
// Counts rising edges of TICK_IN over a WIN-cycle window and reports the
// result through a DONE/ACK handshake; used to verify a divider's N in-system.
module edge_window_counter
  import edge_window_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int WW = WW_DEF
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic          START,
  input  logic [WW-1:0] WIN,
  input  logic          TICK_IN,
  input  logic          ACK,
  output logic [CW-1:0] COUNT,
  output logic          BUSY,
  output logic          DONE,
  output logic          OVF,
  output logic [1:0]    dbg_state
);

  localparam logic [CW-1:0] SAT = CW'(sat_limit(CW));

  state_t        state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          edge_pulse;

  rise_detect u_rise (
    .CLK   (CLK),
    .RES   (RES),
    .level (TICK_IN),
    .pulse (edge_pulse)
  );

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake: START is accepted only in IDLE. The result is offered with
  // DONE=1 and stays stable until ACK is seen in DONE; ACK elsewhere and
  // START outside IDLE (even alongside ACK) are dropped.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          count_d = '0;
          ovf_d   = 1'b0;
          if (WIN != '0) begin
            wcnt_d  = WIN;
            state_d = ST_COUNT;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_COUNT: begin
        if (edge_pulse) begin
          if (count_q == SAT) ovf_d   = 1'b1;
          else                count_d = count_q + CW'(1);
        end
        wcnt_d = wcnt_q - WW'(1);
        if (wcnt_q == WW'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (ACK) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign COUNT     = count_q;
  assign OVF       = ovf_q;
  assign BUSY      = (state_q == ST_COUNT);
  assign DONE      = (state_q == ST_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_edge_window_counter.sv
// Randomized bench for edge_window_counter: a driver issues windows and queues
// the expected {OVF,COUNT}; a monitor pops and compares when DONE is offered.
module tb_edge_window_counter;
  import edge_window_pkg::*;

  localparam int CW = 4;
  localparam int WW = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RES;
  logic          START;
  logic [WW-1:0] WIN;
  logic          TICK_IN;
  logic          ACK;
  logic [CW-1:0] COUNT;
  logic          BUSY;
  logic          DONE;
  logic          OVF;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [CW:0] exp_q[$];
  logic [CW:0] held;
  logic        done_prev = 1'b0;

  edge_window_counter #(.CW(CW), .WW(WW)) dut (
    .CLK       (CLK),
    .RES       (RES),
    .START     (START),
    .WIN       (WIN),
    .TICK_IN   (TICK_IN),
    .ACK       (ACK),
    .COUNT     (COUNT),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .OVF       (OVF),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // monitor / scoreboard
  always @(negedge CLK) begin
    if (DONE && !done_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%0d expected=none", {OVF, COUNT});
      end else begin
        held = exp_q.pop_front();
        check("result_ovf_count", 32'({OVF, COUNT}), 32'(held));
      end
    end else if (DONE) begin
      check("held_ovf_count", 32'({OVF, COUNT}), 32'(held));
    end
    done_prev = DONE;
  end

  // Tick pattern kinds: 0 divider N=8, 1 toggle each cycle, 2 random,
  // 3 rise on the START edge and again on the last sampled edge.
  task automatic make_seq(input int w, input int kind, output bit s[0:257]);
    int ph;
    ph = $urandom_range(0, 15);
    for (int i = 0; i <= w + 1; i++) begin
      case (kind)
        0:       s[i] = (((ph + i) / 8) % 2) == 1;
        1:       s[i] = (i % 2) == 1;
        3:       s[i] = (i == 0) ? 1'b0 : (i == w + 1) ? 1'b1 : (i <= w / 2 + 1);
        default: s[i] = $urandom_range(0, 1) == 1;
      endcase
    end
  endtask

  // s[0] is the level before the START edge, s[1] at the START edge,
  // s[k+1] at the k-th window sample.
  task automatic measure(input int w, input int kind, input int hold, input bit start_ack);
    bit s[0:257];
    int rises;
    make_seq(w, kind, s);
    rises = 0;
    for (int i = 2; i <= w + 1; i++)
      if (s[i] && !s[i-1]) rises++;
    TICK_IN = s[0]; START = 1'b0; ACK = 1'b0;
    step();
    exp_q.push_back({rises > MAXC, CW'((rises > MAXC) ? MAXC : rises)});
    TICK_IN = s[1]; START = 1'b1; WIN = WW'(w);
    step();
    check("busy_after_start", 32'(BUSY), 32'(w != 0));
    check("done_after_start", 32'(DONE), 32'(w == 0));
    for (int i = 2; i <= w + 1; i++) begin
      START = ($urandom_range(0, 1) == 1);
      WIN = WW'($urandom);
      TICK_IN = s[i];
      step();
      check("busy_window", 32'(BUSY), 32'(i < w + 1));
      check("done_window", 32'(DONE), 32'(i == w + 1));
    end
    for (int h = 0; h < hold; h++) begin
      START = ($urandom_range(0, 1) == 1);
      TICK_IN = ($urandom_range(0, 1) == 1);
      step();
      check("done_hold", 32'(DONE), 32'd1);
      check("busy_hold", 32'(BUSY), 32'd0);
    end
    ACK = 1'b1; START = start_ack;
    step();
    check("done_after_ack", 32'(DONE), 32'd0);
    check("busy_after_ack", 32'(BUSY), 32'd0);
    ACK = 1'b0; START = 1'b0;
    step();
    check("idle_after_ack", 32'({BUSY, DONE}), 32'd0);
    ACK = 1'b1;
    step();
    check("ack_in_idle", 32'({BUSY, DONE}), 32'd0);
    ACK = 1'b0;
  endtask

  task automatic reset_mid_window();
    TICK_IN = 1'b0; START = 1'b0;
    step();
    START = 1'b1; WIN = WW'(100);
    step();
    START = 1'b0;
    for (int i = 0; i < 10; i++) begin
      TICK_IN = ~TICK_IN;
      step();
    end
    check("busy_before_reset", 32'(BUSY), 32'd1);
    RES = 1'b0;
    #2;
    check("reset_count", 32'(COUNT), 32'd0);
    check("reset_flags", 32'({BUSY, DONE, OVF}), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    step();
    #3 RES = 1'b1;
    step();
    check("post_reset_idle", 32'({BUSY, DONE}), 32'd0);
  endtask

  initial begin
    RES = 1'b0; START = 1'b0; ACK = 1'b0; WIN = '0; TICK_IN = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_count", 32'(COUNT), 32'd0);
    check("rst_flags", 32'({BUSY, DONE, OVF}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    #3 RES = 1'b1;
    step();
    step();
    check("tick_high_out_of_reset", 32'({COUNT, BUSY, DONE}), 32'd0);

    measure(64, 0, 2, 1'b0);
    measure(0, 2, 1, 1'b0);
    measure(40, 1, 1, 1'b0);
    measure(50, 0, 3, 1'b1);
    reset_mid_window();
    measure(32, 0, 0, 1'b0);
    measure(9, 3, 1, 1'b0);
    measure(1, 1, 0, 1'b1);
    measure(255, 1, 1, 1'b0);
    for (int n = 0; n < 25; n++)
      measure($urandom_range(0, 80), $urandom_range(0, 2), $urandom_range(0, 3),
              $urandom_range(0, 1) == 1);

    repeat (3) step();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_window_counter.md
# edge_window_counter

Downstream measurement stage for the divide-by-N counter output. It counts rising edges of the divider output level (TICK_IN) over a programmable window of WIN clock cycles. It then presents the result with a DONE/ACK handshake, so the divider's programmed N can be checked in-system. One clock domain, shared with the divider.

## Interface
Parameters:
- CW, 8, width of COUNT and of the saturation limit (max 2^CW−1)
- WW, 8, width of WIN and of the internal window down-counter

Ports:
- CLK  input  1  system clock; all state changes on rising edge
- RES  input  1  asynchronous, active-low reset
- START  input  1  one-cycle request to begin a measurement; honoured only in IDLE
- WIN  input  WW  window length in cycles; sampled only on the accepted START cycle
- TICK_IN  input  1  divider output level, synchronous to CLK
- ACK  input  1  consumer acknowledge; honoured only in DONE
- COUNT  output  CW  rising edges counted in the last window; held from DONE until the next accepted START
- BUSY  output  1  high while in COUNT state
- DONE  output  1  high while in DONE state
- OVF  output  1  set when an edge arrives while COUNT = 2^CW−1; cleared on accepted START

## Operation
- Edge detect: register tick_q <= TICK_IN every cycle, in all states; edge = TICK_IN & ~tick_q.
- States: IDLE, COUNT, DONE.
- IDLE:
  - START=1, WIN≠0 → COUNT; wcnt <= WIN; COUNT <= 0; OVF <= 0.
  - START=1, WIN=0 → DONE directly; COUNT <= 0; OVF <= 0.
  - Otherwise stay in IDLE.
- COUNT, every cycle:
  - If edge: COUNT <= COUNT+1, saturating at 2^CW−1. An edge at saturation sets OVF and leaves COUNT unchanged.
  - wcnt <= wcnt−1. When wcnt = 1 this cycle → DONE.
  - START is ignored. WIN changes have no effect.
- DONE:
  - DONE=1; COUNT and OVF are held.
  - ACK=1 → IDLE.
  - START is ignored, including when asserted together with ACK. ACK wins, and START must be re-issued from IDLE.
- ACK outside DONE is ignored.
- RES low at any time, mid-window included: immediate return to IDLE. The partial count is discarded.

## Timing
- Reset values: COUNT=0, BUSY=0, DONE=0, OVF=0, state=IDLE, tick_q=0, wcnt=0.
- START sampled at edge t with WIN=W≥1:
  - BUSY is high after edges t … t+W−1 and low after edge t+W.
  - Edges are evaluated at clock edges t+1 … t+W, i.e. exactly W samples.
  - DONE is high and COUNT is final after edge t+W.
- A TICK_IN rise first sampled at edge t, the START edge, is not counted.
- START with WIN=0 at edge t: DONE=1, COUNT=0 after edge t.
- ACK sampled at edge d in DONE: DONE=0 after edge d. The earliest next accepted START is at edge d+1.
- All outputs are registered; no combinational path from inputs to outputs.
- A TICK_IN that is high out of reset creates no spurious count, because the block cannot be in COUNT in the first cycle after reset.

## Structure
- Shared package edge_window_pkg:
  - state enum {IDLE, COUNT, DONE}, 2 bits
  - default widths CW_DEF=8, WW_DEF=8
  - saturation constant derived from CW
- Sub-module rise_detect: holds the tick_q register and outputs the one-cycle edge pulse; reset to 0 on RES low. It is reused for any other level-to-pulse conversion.
- The top module holds the FSM, wcnt, the COUNT saturating adder and OVF.

## Test plan
- Divider N=8, so TICK_IN rises every 16 cycles. START with WIN=64 → DONE after 64 cycles, COUNT=4, OVF=0. ACK → IDLE, DONE=0 next cycle.
- START with WIN=0 → DONE the next cycle, COUNT=0, BUSY never asserted.
- CW=4, TICK_IN toggling every cycle, so it rises every 2 cycles. WIN=40 → COUNT=15, OVF=1.
- START re-pulsed during COUNT and again during DONE → no restart; the original window length holds and COUNT is unchanged. START+ACK together in DONE → IDLE with no new measurement.
- RES pulled low 10 cycles into a WIN=100 window → all outputs 0 immediately. After release, START with WIN=32 measures cleanly: COUNT=2 with N=8.
- TICK_IN rising exactly at the START edge, then again at edge t+W → the first rise is not counted, the last is counted; COUNT equals the in-window rises only.
